// File: rtl/mc_control_unit_if.sv
// Control bus between the multicycle control unit and its datapath.
// master: the control unit; slave: the datapath (or a testbench standing in for it).
interface mc_control_unit_if;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        z;
  logic [3:0]  aluc;
  logic        pcwr;
  logic        irwr;
  logic        wreg;
  logic        wmem;
  logic        iord;
  logic        m2reg;
  logic        regrt;
  logic        jal;
  logic        sext;
  logic        alusrca;
  logic [1:0]  pcsource;
  logic [1:0]  alusrcb;
  logic [2:0]  state;
  logic [31:0] icount;
  logic        illegal;

  modport master (
    input  op, func, z,
    output aluc, pcwr, irwr, wreg, wmem, iord, m2reg, regrt, jal, sext,
           alusrca, pcsource, alusrcb, state, icount, illegal
  );

  modport slave (
    output op, func, z,
    input  aluc, pcwr, irwr, wreg, wmem, iord, m2reg, regrt, jal, sext,
           alusrca, pcsource, alusrcb, state, icount, illegal
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM with retired-instruction counter.
// Define MC_CONTROL_UNIT_TRAP_EN to make illegal instructions lock in a TRAP state.
module mc_control_unit (
  input  logic               clock,
  input  logic               resetn,
  mc_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b101
  } state_t;

  state_t      state;
  state_t      next;
  logic [31:0] count;

  logic       d_legal, d_j, d_jr, d_jal, d_beq, d_bne, d_lw, d_sw;
  logic       d_itype, d_shift, d_usert, d_zext;
  logic [3:0] d_aluc;

  logic       pcwr_c, irwr_c, wreg_c, wmem_c;
  logic       iord_c, m2reg_c, regrt_c, jal_c, sext_c, alusrca_c;
  logic [1:0] pcsource_c, alusrcb_c;
  logic [3:0] aluc_c;

  // Instruction decode: classifies op/func independent of the current state.
  always_comb begin
    d_legal = 1'b1;
    d_j     = 1'b0;
    d_jr    = 1'b0;
    d_jal   = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_lw    = 1'b0;
    d_sw    = 1'b0;
    d_itype = 1'b0;
    d_shift = 1'b0;
    d_usert = 1'b0;
    d_zext  = 1'b0;
    d_aluc  = 4'b0000;
    case (bus.op)
      6'b000000: begin
        d_usert = 1'b1;
        case (bus.func)
          6'b100000: d_aluc = 4'b0000;
          6'b100010: d_aluc = 4'b0100;
          6'b100100: d_aluc = 4'b0001;
          6'b100101: d_aluc = 4'b0101;
          6'b100110: d_aluc = 4'b0010;
          6'b000000: begin d_aluc = 4'b0011; d_shift = 1'b1; end
          6'b000010: begin d_aluc = 4'b0111; d_shift = 1'b1; end
          6'b000011: begin d_aluc = 4'b1111; d_shift = 1'b1; end
          6'b001000: d_jr = 1'b1;
          default:   d_legal = 1'b0;
        endcase
      end
      6'b001000: d_itype = 1'b1;
      6'b001100: begin d_itype = 1'b1; d_zext = 1'b1; d_aluc = 4'b0001; end
      6'b001101: begin d_itype = 1'b1; d_zext = 1'b1; d_aluc = 4'b0101; end
      6'b001110: begin d_itype = 1'b1; d_zext = 1'b1; d_aluc = 4'b0010; end
      6'b001111: begin d_itype = 1'b1; d_aluc = 4'b0110; end
      6'b100011: begin d_itype = 1'b1; d_lw = 1'b1; end
      6'b101011: d_sw = 1'b1;
      6'b000100: begin d_beq = 1'b1; d_usert = 1'b1; d_aluc = 4'b0100; end
      6'b000101: begin d_bne = 1'b1; d_usert = 1'b1; d_aluc = 4'b0100; end
      6'b000010: d_j = 1'b1;
      6'b000011: d_jal = 1'b1;
      default:   d_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IF;
      count <= 32'd0;
    end else begin
      state <= next;
      if ((state != S_IF) && (next == S_IF)) begin
        count <= count + 32'd1;
      end
    end
  end

  // Next state and per-state control outputs; anything not set here stays 0.
  always_comb begin
    next       = state;
    pcwr_c     = 1'b0;
    irwr_c     = 1'b0;
    wreg_c     = 1'b0;
    wmem_c     = 1'b0;
    iord_c     = 1'b0;
    m2reg_c    = 1'b0;
    regrt_c    = 1'b0;
    jal_c      = 1'b0;
    sext_c     = 1'b0;
    alusrca_c  = 1'b0;
    pcsource_c = 2'b00;
    alusrcb_c  = 2'b00;
    aluc_c     = 4'b0000;
    case (state)
      S_IF: begin
        irwr_c    = 1'b1;
        pcwr_c    = 1'b1;
        alusrcb_c = 2'b01;
        next      = S_ID;
      end
      S_ID: begin
        alusrcb_c = 2'b11;
        if (!d_legal) begin
`ifdef MC_CONTROL_UNIT_TRAP_EN
          next = S_TRAP;
`else
          next = S_IF;
`endif
        end else if (d_j) begin
          pcwr_c     = 1'b1;
          pcsource_c = 2'b11;
          next       = S_IF;
        end else if (d_jr) begin
          pcwr_c     = 1'b1;
          pcsource_c = 2'b10;
          next       = S_IF;
        end else if (d_jal) begin
          pcwr_c     = 1'b1;
          pcsource_c = 2'b11;
          wreg_c     = 1'b1;
          jal_c      = 1'b1;
          next       = S_IF;
        end else begin
          next = S_EXE;
        end
      end
      S_EXE: begin
        aluc_c    = d_aluc;
        alusrca_c = d_shift;
        alusrcb_c = d_usert ? 2'b00 : 2'b10;
        sext_c    = ~d_zext;
        if (d_beq || d_bne) begin
          if ((d_beq && bus.z) || (d_bne && !bus.z)) begin
            pcwr_c     = 1'b1;
            pcsource_c = 2'b01;
          end
          next = S_IF;
        end else if (d_lw || d_sw) begin
          next = S_MEM;
        end else begin
          next = S_WB;
        end
      end
      S_MEM: begin
        iord_c = 1'b1;
        wmem_c = d_sw;
        next   = d_lw ? S_WB : S_IF;
      end
      S_WB: begin
        wreg_c  = 1'b1;
        m2reg_c = d_lw;
        regrt_c = d_itype;
        next    = S_IF;
      end
      S_TRAP: begin
`ifdef MC_CONTROL_UNIT_TRAP_EN
        next = S_TRAP;
`else
        next = S_IF;
`endif
      end
      default: next = S_IF;
    endcase
  end

  // Write enables are gated by reset so an abandoned instruction never commits.
  assign bus.pcwr     = pcwr_c & resetn;
  assign bus.irwr     = irwr_c & resetn;
  assign bus.wreg     = wreg_c & resetn;
  assign bus.wmem     = wmem_c & resetn;
  assign bus.iord     = iord_c;
  assign bus.m2reg    = m2reg_c;
  assign bus.regrt    = regrt_c;
  assign bus.jal      = jal_c;
  assign bus.sext     = sext_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.pcsource = pcsource_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.aluc     = aluc_c;
  assign bus.state    = state;
  assign bus.icount   = count;

`ifdef MC_CONTROL_UNIT_TRAP_EN
  assign bus.illegal = (state == S_TRAP);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: instruction vector table plus
// hand-written reset, counter-wrap and illegal-instruction sequences.
module tb_mc_control_unit;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    int         lat;
    logic [3:0] aluc;
    logic       asa;
    logic [1:0] asb;
    logic       sext;
    logic       idpc;
    logic [1:0] idsrc;
    logic       idwreg;
    logic       idjal;
    logic       taken;
    logic       wmem;
    logic       m2reg;
    logic       regrt;
  } vec_t;

`ifdef MC_CONTROL_UNIT_TRAP_EN
  localparam int NV = 23;
`else
  localparam int NV = 25;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NV];

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] func, input logic z);
    bus.op   = op;
    bus.func = func;
    bus.z    = z;
  endtask

  // Runs one instruction from IF until the FSM returns to IF, checking each state.
  task automatic runVec(input vec_t v, input int idx);
    logic [31:0] startCount;
    int          cycles;
    startCount = bus.icount;
    cycles     = 0;
    applyStimulus(v.op, v.func, v.z);
    #1;
    checkOutput($sformatf("v%0d.if.state", idx), {29'd0, bus.state}, 32'd0);
    checkOutput($sformatf("v%0d.if.irwr", idx), {31'd0, bus.irwr}, 32'd1);
    checkOutput($sformatf("v%0d.if.pcwr", idx), {31'd0, bus.pcwr}, 32'd1);
    checkOutput($sformatf("v%0d.if.alusrcb", idx), {30'd0, bus.alusrcb}, 32'd1);
    checkOutput($sformatf("v%0d.if.wreg", idx), {31'd0, bus.wreg}, 32'd0);
    do begin
      @(posedge clock);
      #1;
      cycles++;
      case (bus.state)
        3'b000: ;
        3'b001: begin
          checkOutput($sformatf("v%0d.id.alusrcb", idx), {30'd0, bus.alusrcb}, 32'd3);
          checkOutput($sformatf("v%0d.id.pcwr", idx), {31'd0, bus.pcwr}, {31'd0, v.idpc});
          checkOutput($sformatf("v%0d.id.pcsource", idx), {30'd0, bus.pcsource}, {30'd0, v.idsrc});
          checkOutput($sformatf("v%0d.id.wreg", idx), {31'd0, bus.wreg}, {31'd0, v.idwreg});
          checkOutput($sformatf("v%0d.id.jal", idx), {31'd0, bus.jal}, {31'd0, v.idjal});
          checkOutput($sformatf("v%0d.id.illegal", idx), {31'd0, bus.illegal}, 32'd0);
        end
        3'b010: begin
          checkOutput($sformatf("v%0d.exe.aluc", idx), {28'd0, bus.aluc}, {28'd0, v.aluc});
          checkOutput($sformatf("v%0d.exe.alusrca", idx), {31'd0, bus.alusrca}, {31'd0, v.asa});
          checkOutput($sformatf("v%0d.exe.alusrcb", idx), {30'd0, bus.alusrcb}, {30'd0, v.asb});
          checkOutput($sformatf("v%0d.exe.sext", idx), {31'd0, bus.sext}, {31'd0, v.sext});
          checkOutput($sformatf("v%0d.exe.pcwr", idx), {31'd0, bus.pcwr}, {31'd0, v.taken});
          checkOutput($sformatf("v%0d.exe.pcsource", idx), {30'd0, bus.pcsource}, v.taken ? 32'd1 : 32'd0);
          checkOutput($sformatf("v%0d.exe.wreg", idx), {31'd0, bus.wreg}, 32'd0);
        end
        3'b011: begin
          checkOutput($sformatf("v%0d.mem.iord", idx), {31'd0, bus.iord}, 32'd1);
          checkOutput($sformatf("v%0d.mem.wmem", idx), {31'd0, bus.wmem}, {31'd0, v.wmem});
          checkOutput($sformatf("v%0d.mem.wreg", idx), {31'd0, bus.wreg}, 32'd0);
        end
        3'b100: begin
          checkOutput($sformatf("v%0d.wb.wreg", idx), {31'd0, bus.wreg}, 32'd1);
          checkOutput($sformatf("v%0d.wb.m2reg", idx), {31'd0, bus.m2reg}, {31'd0, v.m2reg});
          checkOutput($sformatf("v%0d.wb.regrt", idx), {31'd0, bus.regrt}, {31'd0, v.regrt});
          checkOutput($sformatf("v%0d.wb.wmem", idx), {31'd0, bus.wmem}, 32'd0);
        end
        default: checkOutput($sformatf("v%0d.unexpected_state", idx), {29'd0, bus.state}, 32'd0);
      endcase
    end while (bus.state != 3'b000 && cycles < 12);
    checkOutput($sformatf("v%0d.latency", idx), cycles, v.lat);
    checkOutput($sformatf("v%0d.icount", idx), bus.icount, startCount + 32'd1);
  endtask

  initial begin
    //         op     func   z     lat aluc     asa   asb    sext  idpc  idsrc  idwreg idjal taken wmem  m2reg regrt
    vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, 4'b0100, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{6'h00, 6'h24, 1'b0, 4, 4'b0001, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 4, 4'b0101, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'h00, 6'h26, 1'b0, 4, 4'b0010, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'h00, 6'h00, 1'b0, 4, 4'b0011, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'h00, 6'h02, 1'b0, 4, 4'b0111, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'h00, 6'h03, 1'b0, 4, 4'b1111, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'h00, 6'h08, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'h08, 6'h15, 1'b0, 4, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{6'h0c, 6'h15, 1'b0, 4, 4'b0001, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{6'h0d, 6'h15, 1'b0, 4, 4'b0101, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{6'h0e, 6'h15, 1'b0, 4, 4'b0010, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{6'h0f, 6'h15, 1'b0, 4, 4'b0110, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{6'h23, 6'h15, 1'b0, 5, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{6'h2b, 6'h15, 1'b0, 4, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{6'h04, 6'h15, 1'b1, 3, 4'b0100, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{6'h04, 6'h15, 1'b0, 3, 4'b0100, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{6'h05, 6'h15, 1'b0, 3, 4'b0100, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{6'h05, 6'h15, 1'b1, 3, 4'b0100, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{6'h02, 6'h00, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{6'h03, 6'h00, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{6'h00, 6'h20, 1'b1, 4, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifndef MC_CONTROL_UNIT_TRAP_EN
    vecs[23] = '{6'h3f, 6'h00, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[24] = '{6'h00, 6'h3f, 1'b0, 2, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    applyStimulus(6'h00, 6'h20, 1'b0);
    #12;
    checkOutput("reset.state", {29'd0, bus.state}, 32'd0);
    checkOutput("reset.icount", bus.icount, 32'd0);
    checkOutput("reset.illegal", {31'd0, bus.illegal}, 32'd0);
    checkOutput("reset.pcwr", {31'd0, bus.pcwr}, 32'd0);
    checkOutput("reset.irwr", {31'd0, bus.irwr}, 32'd0);
    checkOutput("reset.wreg", {31'd0, bus.wreg}, 32'd0);
    checkOutput("reset.wmem", {31'd0, bus.wmem}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      runVec(vecs[i], i);
    end
    checkOutput("icount.total", bus.icount, NV);
    checkOutput("illegal.after_table", {31'd0, bus.illegal}, 32'd0);

    force dut.count = 32'hFFFF_FFFF;
    #1;
    release dut.count;
    checkOutput("icount.preload", bus.icount, 32'hFFFF_FFFF);
    runVec(vecs[20], 100);
    checkOutput("icount.wrap", bus.icount, 32'd0);

    // Reset arriving in the EXE cycle of a store must suppress the memory write.
    applyStimulus(6'h2b, 6'h15, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("swrst.in_exe", {29'd0, bus.state}, 32'd2);
    resetn = 1'b0;
    #1;
    checkOutput("swrst.state", {29'd0, bus.state}, 32'd0);
    checkOutput("swrst.wmem", {31'd0, bus.wmem}, 32'd0);
    checkOutput("swrst.pcwr", {31'd0, bus.pcwr}, 32'd0);
    checkOutput("swrst.irwr", {31'd0, bus.irwr}, 32'd0);
    checkOutput("swrst.icount", bus.icount, 32'd0);
    @(posedge clock); #1;
    checkOutput("swrst.held_state", {29'd0, bus.state}, 32'd0);
    checkOutput("swrst.held_wmem", {31'd0, bus.wmem}, 32'd0);
    applyStimulus(6'h00, 6'h20, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    runVec(vecs[0], 101);

`ifdef MC_CONTROL_UNIT_TRAP_EN
    applyStimulus(6'h3f, 6'h00, 1'b0);
    @(posedge clock); #1;
    checkOutput("trap.id", {29'd0, bus.state}, 32'd1);
    @(posedge clock); #1;
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("trap.state.%0d", c), {29'd0, bus.state}, 32'd5);
      checkOutput($sformatf("trap.illegal.%0d", c), {31'd0, bus.illegal}, 32'd1);
      checkOutput($sformatf("trap.pcwr.%0d", c), {31'd0, bus.pcwr}, 32'd0);
      checkOutput($sformatf("trap.irwr.%0d", c), {31'd0, bus.irwr}, 32'd0);
      checkOutput($sformatf("trap.wreg.%0d", c), {31'd0, bus.wreg}, 32'd0);
      @(posedge clock); #1;
    end
    checkOutput("trap.icount", bus.icount, 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("trap.rst_state", {29'd0, bus.state}, 32'd0);
    checkOutput("trap.rst_illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
`else
    applyStimulus(6'h3f, 6'h00, 1'b0);
    @(posedge clock); #1;
    checkOutput("nop.id", {29'd0, bus.state}, 32'd1);
    checkOutput("nop.illegal", {31'd0, bus.illegal}, 32'd0);
    @(posedge clock); #1;
    checkOutput("nop.back_if", {29'd0, bus.state}, 32'd0);
    checkOutput("nop.icount", bus.icount, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports op and func, input, 6 each, opcode and function fields from the instruction register.
REQ-004 SHALL have port z, input, 1, ALU zero flag.
REQ-005 SHALL have port aluc, output, 4, ALU op: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
REQ-006 SHALL have ports pcwr, irwr, wreg, wmem, iord, m2reg, regrt, jal, sext, alusrca, output, 1 each, datapath enables and selects.
REQ-007 SHALL have ports pcsource and alusrcb, output, 2 each: pcsource 00 ALU, 01 ALUOut, 10 rs, 11 jump target; alusrcb 00 rt, 01 const 4, 10 imm, 11 imm<<2.
REQ-008 SHALL have ports state, output, 3, current state; icount, output, 32, retired-instruction count; illegal, output, 1, trap flag.

Function
REQ-009 States SHALL be IF=000, ID=001, EXE=010, MEM=011, WB=100, TRAP=101; all outputs combinational from state, op, func and z.
REQ-010 SHALL decode add sub and or xor sll srl sra jr (op 0) and addi andi ori xori lui lw sw beq bne j jal; any other op/func is illegal.
REQ-011 IF: irwr=1, pcwr=1, pcsource=00, alusrca=0, alusrcb=01, aluc=0000; next ID.
REQ-012 ID: alusrcb=11, aluc=0000 (branch target); j: pcwr=1, pcsource=11; jr: pcwr=1, pcsource=10; jal: pcwr=1, pcsource=11, wreg=1, jal=1; next IF for j/jr/jal, EXE for other legal instructions.
REQ-013 EXE: aluc per instruction; alusrca=1 for sll/srl/sra (shift amount); alusrcb=00 R-type, 10 I-type; sext=0 for andi/ori/xori, else 1; beq/bne use aluc=0100.
REQ-014 EXE branch: pcwr=1 and pcsource=01 in the same cycle iff (beq and z=1) or (bne and z=0); next IF for branches, MEM for lw/sw, WB otherwise.
REQ-015 MEM: iord=1; wmem=1 for sw only; next WB for lw, IF for sw.
REQ-016 WB: wreg=1; m2reg=1 for lw; regrt=1 for I-type; next IF.
REQ-017 Instruction latency SHALL be: j/jr/jal 2, beq/bne 3, sw 4, lw 5, all others 4 cycles.
REQ-018 icount SHALL increment by 1 on every transition into IF from any non-IF state, wrapping 0xFFFFFFFF -> 0.
REQ-019 Outputs not listed for a state SHALL be 0.

Reset
REQ-020 resetn low SHALL immediately force state=IF, icount=0, illegal=0, and force pcwr, irwr, wreg, wmem to 0 regardless of state.
REQ-021 First rising edge with resetn high SHALL perform a normal IF; reset mid-instruction SHALL abandon that instruction without any register/memory write.

Configuration
REQ-022 With MC_CONTROL_UNIT_TRAP_EN defined, an illegal instruction in ID SHALL transition to TRAP; TRAP asserts illegal=1, all enables 0, and holds until reset.
REQ-023 Without MC_CONTROL_UNIT_TRAP_EN, an illegal instruction SHALL act as a 2-cycle NOP (ID->IF, no writes, counted in icount), TRAP is unreachable, and illegal is constant 0.

Verification
REQ-024 Reset then op=0/func=100000 (add) -> states IF,ID,EXE,WB,IF; aluc=0000 in EXE; wreg=1 only in WB; icount=1.
REQ-025 beq with z=1 in EXE -> pcwr=1, pcsource=01 in EXE, back to IF after 3 cycles; same with z=0 -> pcwr=0 in EXE.
REQ-026 lw (op 100011) -> IF,ID,EXE,MEM,WB; iord=1 in MEM; m2reg=1, regrt=1, wreg=1 in WB; sw (op 101011) -> wmem=1 in MEM, returns to IF, wreg never 1.
REQ-027 jal (op 000011) -> pcwr=1, pcsource=11, wreg=1, jal=1 in ID, next state IF.
REQ-028 op=111111 -> with MC_CONTROL_UNIT_TRAP_EN: state=101, illegal=1 held for 10 cycles, cleared by resetn=0; without: ID->IF, icount+1.
REQ-029 Preload icount=0xFFFFFFFF via repeated instructions (or force), retire one more -> icount=0; resetn low in EXE of sw -> wmem never asserted, state=IF.
